// File: rtl/call_stack_if.sv
// ---------------------------------------------------------------------------
// call_stack_if
// Push/pop interface between the CPU datapath (master) and the hardware
// return-address stack (slave).
//   push_signal / pop_signal : request strobes, sampled on the rising edge
//   push                     : address to store (current PC)
//   pop                      : combinational top-of-stack value
//   empty / full / count     : occupancy, decoded from the stack pointer
//   overflow / underflow     : sticky error flags, cleared only by reset
// ---------------------------------------------------------------------------
interface call_stack_if #(
    parameter int WIDTH = 10
);
    logic             push_signal;
    logic             pop_signal;
    logic [WIDTH-1:0] push;
    logic [WIDTH-1:0] pop;
    logic             empty;
    logic             full;
    logic [4:0]       count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push_signal, pop_signal, push,
        input  pop, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push_signal, pop_signal, push,
        output pop, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/call_stack.sv
// ---------------------------------------------------------------------------
// call_stack
// Parameterised LIFO holding return addresses for the single-cycle CPU.
// Top-of-stack is read combinationally so a return can use it in the same
// cycle; pointer, storage and sticky error flags update on the rising edge.
//   i_clk   : system clock
//   i_reset : asynchronous, active-high reset (pointer and flags)
//   bus     : call_stack_if slave port (requests in, stack status out)
// ---------------------------------------------------------------------------
module call_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    call_stack_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = DEPTH[4:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [4:0]       r_sp;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic [4:0]       w_sp_m1;
    logic [WIDTH-1:0] w_top;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;
    logic [4:0]       w_sp_nxt;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_empty = (r_sp == 5'd0);
    assign w_full  = (r_sp == DEPTH_C);
    assign w_sp_m1 = r_sp - 5'd1;

    // Top-of-stack read; zero when empty so stale entries never leak out.
    always_comb begin
        w_top = '0;
        if (!w_empty) begin
            w_top = r_mem[w_sp_m1[AW-1:0]];
        end else begin
            w_top = '0;
        end
    end

    // Request decode: write strobe/index, next pointer and flag set terms.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = r_sp[AW-1:0];
        w_sp_nxt  = r_sp;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case ({bus.push_signal, bus.pop_signal})
            2'b10: begin
                if (!w_full) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = r_sp[AW-1:0];
                    w_sp_nxt = r_sp + 5'd1;
                end else begin
                    w_ovf_set = 1'b1;
                end
            end
            2'b01: begin
                if (!w_empty) begin
                    w_sp_nxt = w_sp_m1;
                end else begin
                    w_unf_set = 1'b1;
                end
            end
            2'b11: begin
                // Replace-top; on an empty stack this degrades to a plain push
                // (an empty stack can never be full since DEPTH >= 2).
                if (!w_empty) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = w_sp_m1[AW-1:0];
                end else begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = r_sp[AW-1:0];
                    w_sp_nxt = r_sp + 5'd1;
                end
            end
            default: begin
                w_wr_en  = 1'b0;
                w_sp_nxt = r_sp;
            end
        endcase
    end

    // Pointer and sticky flags; reset discards all entries immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sp        <= 5'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_nxt;
            r_overflow  <= r_overflow  | w_ovf_set;
            r_underflow <= r_underflow | w_unf_set;
        end
    end

    // Entry storage; contents are unobservable while the pointer is zero,
    // so it carries no reset, but writes are suppressed while reset is high.
    always_ff @(posedge i_clk) begin
        if (w_wr_en && !i_reset) begin
            r_mem[w_wr_idx] <= bus.push;
        end
    end

    assign bus.pop       = w_top;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_sp;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule
